// File: rtl/dtw_axis_pkg.sv
// Shared definitions for the DTW AXI-Stream packet master: start FSM encoding
// and an elaboration-time clog2 helper.
package dtw_axis_pkg;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_START = 2'd1;
    localparam logic [1:0] ST_STREAM     = 2'd2;

    // Returns at least 1 so that it can always be used as a vector width
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/dtw_axis_pkt_master_if.sv
// AXI4-Stream bundle between the packet master and its downstream consumer.
interface dtw_axis_pkt_master_if #(
    parameter int unsigned DATA_W = 32
);
    logic                  tvalid;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tstrb;
    logic                  tlast;
    logic                  tready;

    modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tstrb, input tlast, output tready);
endinterface

// File: rtl/dtw_sync_fifo.sv
// Single-clock FIFO with registered level, full, almost-full and sticky
// overflow flags. Read data is the combinational head-of-queue word.
module dtw_sync_fifo
    import dtw_axis_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data_c,
    output logic                          full,
    output logic                          afull,
    output logic                          ovf,
    output logic [clog2(DEPTH+1)-1:0]     level
);
    localparam int unsigned AW    = clog2(DEPTH);
    localparam int unsigned LVL_W = clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              full_q, full_d, afull_q, afull_d, ovf_q, ovf_d;
    logic              wr_ok_c;

    // Flags are derived from the next level so they line up with level_q
    always_comb begin
        wr_ok_c  = wr_en && !full_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q | (wr_en & full_q);
        if (wr_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en)   rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_ok_c, rd_en})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        full_d  = (level_d == LVL_W'(DEPTH));
        afull_d = (level_d >= LVL_W'(AFULL_THRESH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok_c) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data_c = mem_q[rd_ptr_q];
    assign full      = full_q;
    assign afull     = afull_q;
    assign ovf       = ovf_q;
    assign level     = level_q;

endmodule

// File: rtl/dtw_axis_pkt_master.sv
// Buffers DTW core output in a FIFO and emits it as AXI4-Stream packets of
// pkt_len beats, with an early-close flush and a post-reset start delay.
module dtw_axis_pkt_master
    import dtw_axis_pkg::*;
#(
    parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_FIFO_DEPTH         = 16,
    parameter int unsigned C_AFULL_THRESH       = 12,
    parameter int unsigned C_PKT_LEN_MAX        = 256,
    parameter int unsigned C_M_START_COUNT      = 32
) (
    input  logic                                  M_AXIS_ACLK,
    input  logic                                  M_AXIS_ARESET,
    input  logic                                  dtw_fifo_wren,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]       dtw_fifo_din,
    output logic                                  dtw_fifo_full,
    output logic                                  dtw_fifo_afull,
    output logic                                  dtw_fifo_ovf,
    output logic [clog2(C_FIFO_DEPTH+1)-1:0]      fifo_level,
    input  logic [clog2(C_PKT_LEN_MAX+1)-1:0]     pkt_len,
    input  logic                                  flush,
    dtw_axis_pkt_master_if.master                 m_axis
);
    localparam int unsigned DW    = C_M_AXIS_TDATA_WIDTH;
    localparam int unsigned LVL_W = clog2(C_FIFO_DEPTH + 1);
    localparam int unsigned LEN_W = clog2(C_PKT_LEN_MAX + 1);
    localparam int unsigned CNT_W = clog2(C_M_START_COUNT + 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] start_cnt_q, start_cnt_d;
    logic             tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [DW-1:0]    tdata_q, tdata_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d, len_q, len_d;
    logic             flush_pend_q, flush_pend_d;
    logic [LEN_W-1:0] pkt_len_c, len_eff_c;
    logic             load_c, last_c, flush_close_c;
    logic [DW-1:0]    rd_data_c;

    dtw_sync_fifo #(
        .DATA_W       (DW),
        .DEPTH        (C_FIFO_DEPTH),
        .AFULL_THRESH (C_AFULL_THRESH)
    ) u_fifo (
        .clk       (M_AXIS_ACLK),
        .rst       (M_AXIS_ARESET),
        .wr_en     (dtw_fifo_wren),
        .wr_data   (dtw_fifo_din),
        .rd_en     (load_c),
        .rd_data_c (rd_data_c),
        .full      (dtw_fifo_full),
        .afull     (dtw_fifo_afull),
        .ovf       (dtw_fifo_ovf),
        .level     (fifo_level)
    );

    always_comb begin
        state_d       = state_q;
        start_cnt_d   = start_cnt_q;
        tvalid_d      = tvalid_q;
        tdata_d       = tdata_q;
        tlast_d       = tlast_q;
        beat_cnt_d    = beat_cnt_q;
        len_d         = len_q;
        flush_pend_d  = flush_pend_q;

        // Start delay: one IDLE cycle, then C_M_START_COUNT cycles of WAIT_START
        case (state_q)
            ST_IDLE:       state_d = ST_WAIT_START;
            ST_WAIT_START: begin
                if (start_cnt_q == CNT_W'(C_M_START_COUNT - 1)) state_d = ST_STREAM;
                else start_cnt_d = start_cnt_q + CNT_W'(1);
            end
            ST_STREAM:     state_d = ST_STREAM;
            default:       state_d = ST_IDLE;
        endcase

        pkt_len_c = pkt_len;
        if (pkt_len == '0)                            pkt_len_c = LEN_W'(1);
        else if (pkt_len > LEN_W'(C_PKT_LEN_MAX))     pkt_len_c = LEN_W'(C_PKT_LEN_MAX);

        // Packet length is frozen at the first beat of each packet
        len_eff_c     = (beat_cnt_q == '0) ? pkt_len_c : len_q;
        flush_close_c = flush_pend_q && (fifo_level == LVL_W'(1));
        last_c        = (beat_cnt_q == len_eff_c - LEN_W'(1)) || flush_close_c;
        load_c        = (state_q == ST_STREAM) && (fifo_level != '0) &&
                        (!tvalid_q || m_axis.tready);

        if (load_c) begin
            tvalid_d = 1'b1;
            tdata_d  = rd_data_c;
            tlast_d  = last_c;
            len_d    = len_eff_c;
            if (last_c) beat_cnt_d = '0;
            else        beat_cnt_d = beat_cnt_q + LEN_W'(1);
            if (flush_close_c) flush_pend_d = 1'b0;
        end else if (tvalid_q && m_axis.tready) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end

        // A flush with nothing open and nothing buffered has nothing to close
        if (flush_pend_q && (beat_cnt_q == '0) && (fifo_level == '0)) flush_pend_d = 1'b0;
        if (flush) flush_pend_d = 1'b1;
    end

    always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
        if (M_AXIS_ARESET) begin
            state_q      <= ST_IDLE;
            start_cnt_q  <= '0;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            beat_cnt_q   <= '0;
            len_q        <= LEN_W'(1);
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_cnt_q  <= start_cnt_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            beat_cnt_q   <= beat_cnt_d;
            len_q        <= len_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tstrb  = '1;

endmodule

// File: tb/tb_dtw_axis_pkt_master.sv
// Directed self-checking bench for dtw_axis_pkt_master (default parameters).
module tb_dtw_axis_pkt_master;
    localparam int unsigned DW    = 32;
    localparam int unsigned LVW   = 5;
    localparam int unsigned PLW   = 9;

    logic            clk = 1'b0;
    logic            rst;
    logic            wren;
    logic [DW-1:0]   din;
    logic            full, afull, ovf;
    logic [LVW-1:0]  level;
    logic [PLW-1:0]  pkt_len;
    logic            flush;

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;

    logic [DW-1:0]   cap_data[$];
    logic            cap_last[$];
    int unsigned     cap_cyc[$];

    dtw_axis_pkt_master_if #(.DATA_W(DW)) axis_if();

    dtw_axis_pkt_master dut (
        .M_AXIS_ACLK    (clk),
        .M_AXIS_ARESET  (rst),
        .dtw_fifo_wren  (wren),
        .dtw_fifo_din   (din),
        .dtw_fifo_full  (full),
        .dtw_fifo_afull (afull),
        .dtw_fifo_ovf   (ovf),
        .fifo_level     (level),
        .pkt_len        (pkt_len),
        .flush          (flush),
        .m_axis         (axis_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Beats are recorded mid-cycle, one per accepted handshake
    always @(negedge clk) begin
        if (!rst && axis_if.tvalid && axis_if.tready) begin
            cap_data.push_back(axis_if.tdata);
            cap_last.push_back(axis_if.tlast);
            cap_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cap();
        cap_data.delete();
        cap_last.delete();
        cap_cyc.delete();
    endtask

    task automatic write_words(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            wren = 1'b1;
            din  = base + DW'(i);
            tick();
        end
        wren = 1'b0;
        din  = '0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int b;
        b = 0;
        while (cap_data.size() < n && b < budget) begin
            tick();
            b++;
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; wren = 1'b0; din = '0; pkt_len = PLW'(4); flush = 1'b0;
        axis_if.tready = 1'b0;
        repeat (3) tick();
        checks++; if (axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", axis_if.tvalid); end
        checks++; if (axis_if.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b exp=0", axis_if.tlast); end
        checks++; if (axis_if.tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got=%h exp=0", axis_if.tdata); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (afull !== 1'b0) begin errors++; $display("FAIL reset_afull got=%b exp=0", afull); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        checks++; if (axis_if.tstrb !== 4'hF) begin errors++; $display("FAIL tstrb got=%h exp=f", axis_if.tstrb); end
    endtask

    task automatic test_wait_start();
        int early;
        early = 0;
        clear_cap();
        pkt_len = PLW'(3);
        axis_if.tready = 1'b1;
        rst = 1'b0;
        // One IDLE edge plus 32 WAIT_START edges before the first load
        for (int k = 1; k <= 33; k++) begin
            wren = (k <= 3);
            din  = 32'hA0 + DW'(k);
            tick();
            if (axis_if.tvalid !== 1'b0) early++;
        end
        wren = 1'b0;
        checks++; if (early != 0) begin errors++; $display("FAIL start_tvalid_early got=%0d cycles high exp=0", early); end
        tick();
        checks++; if (axis_if.tvalid !== 1'b1) begin errors++; $display("FAIL start_first_valid got=%b exp=1", axis_if.tvalid); end
        checks++; if (axis_if.tdata !== 32'hA1) begin errors++; $display("FAIL start_first_data got=%h exp=a1", axis_if.tdata); end
        wait_beats(3, 20);
        checks++; if (cap_data.size() != 3) begin errors++; $display("FAIL start_beats got=%0d exp=3", cap_data.size()); end
        for (int i = 0; i < 3 && i < cap_data.size(); i++) begin
            checks++; if (cap_data[i] !== 32'hA1 + DW'(i) || cap_last[i] !== (i == 2)) begin
                errors++; $display("FAIL start_beat%0d got=%h/%b exp=%h/%b", i, cap_data[i], cap_last[i], 32'hA1 + DW'(i), (i == 2));
            end
        end
    endtask

    task automatic test_basic();
        logic b2b;
        clear_cap();
        pkt_len = PLW'(4);
        axis_if.tready = 1'b1;
        write_words(8, 32'd1);
        wait_beats(8, 20);
        checks++; if (cap_data.size() != 8) begin errors++; $display("FAIL basic_beats got=%0d exp=8", cap_data.size()); end
        b2b = 1'b1;
        for (int i = 0; i < 8 && i < cap_data.size(); i++) begin
            checks++; if (cap_data[i] !== DW'(i + 1) || cap_last[i] !== (i % 4 == 3)) begin
                errors++; $display("FAIL basic_beat%0d got=%h/%b exp=%h/%b", i, cap_data[i], cap_last[i], i + 1, (i % 4 == 3));
            end
            if (cap_cyc[i] != cap_cyc[0] + i) b2b = 1'b0;
        end
        checks++; if (b2b !== 1'b1) begin errors++; $display("FAIL basic_back_to_back got=gap exp=contiguous"); end
    endtask

    task automatic test_len_clamp();
        int nlast;
        clear_cap();
        pkt_len = PLW'(0);
        write_words(2, 32'h50);
        wait_beats(2, 20);
        checks++; if (cap_data.size() != 2) begin errors++; $display("FAIL len0_beats got=%0d exp=2", cap_data.size()); end
        for (int i = 0; i < 2 && i < cap_data.size(); i++) begin
            checks++; if (cap_last[i] !== 1'b1) begin errors++; $display("FAIL len0_last%0d got=%b exp=1", i, cap_last[i]); end
        end
        clear_cap();
        pkt_len = PLW'(300);
        write_words(256, 32'h1000);
        wait_beats(256, 300);
        nlast = 0;
        foreach (cap_last[i]) if (cap_last[i]) nlast++;
        checks++; if (cap_data.size() != 256) begin errors++; $display("FAIL lenmax_beats got=%0d exp=256", cap_data.size()); end
        checks++; if (nlast != 1) begin errors++; $display("FAIL lenmax_nlast got=%0d exp=1", nlast); end
        if (cap_last.size() == 256) begin
            checks++; if (cap_last[255] !== 1'b1) begin errors++; $display("FAIL lenmax_last_pos got=%b exp=1", cap_last[255]); end
        end
    endtask

    task automatic test_flush();
        clear_cap();
        pkt_len = PLW'(8);
        axis_if.tready = 1'b0;
        write_words(3, 32'h31);
        tick();
        flush = 1'b1; tick(); flush = 1'b0;
        tick();
        axis_if.tready = 1'b1;
        wait_beats(3, 20);
        checks++; if (cap_data.size() != 3) begin errors++; $display("FAIL flush_beats got=%0d exp=3", cap_data.size()); end
        for (int i = 0; i < 3 && i < cap_data.size(); i++) begin
            checks++; if (cap_data[i] !== 32'h31 + DW'(i) || cap_last[i] !== (i == 2)) begin
                errors++; $display("FAIL flush_beat%0d got=%h/%b exp=%h/%b", i, cap_data[i], cap_last[i], 32'h31 + DW'(i), (i == 2));
            end
        end
        clear_cap();
        write_words(8, 32'h40);
        wait_beats(8, 20);
        checks++; if (cap_data.size() != 8) begin errors++; $display("FAIL flush_next_beats got=%0d exp=8", cap_data.size()); end
        for (int i = 0; i < 8 && i < cap_data.size(); i++) begin
            checks++; if (cap_last[i] !== (i == 7)) begin errors++; $display("FAIL flush_next_last%0d got=%b exp=%b", i, cap_last[i], (i == 7)); end
        end
        // Flush with nothing open must vanish without a beat
        clear_cap();
        flush = 1'b1; tick(); flush = 1'b0;
        repeat (3) tick();
        checks++; if (cap_data.size() != 0) begin errors++; $display("FAIL flush_empty_beats got=%0d exp=0", cap_data.size()); end
        pkt_len = PLW'(2);
        write_words(2, 32'h60);
        wait_beats(2, 20);
        checks++; if (cap_data.size() != 2) begin errors++; $display("FAIL flush_empty_next got=%0d exp=2", cap_data.size()); end
        for (int i = 0; i < 2 && i < cap_data.size(); i++) begin
            checks++; if (cap_last[i] !== (i == 1)) begin errors++; $display("FAIL flush_empty_last%0d got=%b exp=%b", i, cap_last[i], (i == 1)); end
        end
    endtask

    task automatic test_stall();
        logic          s_v, s_r, s_l;
        logic [DW-1:0] s_d;
        int            it;
        clear_cap();
        pkt_len = PLW'(6);
        axis_if.tready = 1'b0;
        write_words(6, 32'h70);
        it = 0;
        while (cap_data.size() < 6 && it < 40) begin
            axis_if.tready = (it % 2 == 0);
            s_v = axis_if.tvalid; s_r = axis_if.tready; s_d = axis_if.tdata; s_l = axis_if.tlast;
            tick();
            if (s_v && !s_r) begin
                checks++; if (axis_if.tvalid !== 1'b1 || axis_if.tdata !== s_d || axis_if.tlast !== s_l) begin
                    errors++; $display("FAIL stall_hold got=%b/%h/%b exp=1/%h/%b", axis_if.tvalid, axis_if.tdata, axis_if.tlast, s_d, s_l);
                end
            end
            it++;
        end
        axis_if.tready = 1'b1;
        repeat (3) tick();
        checks++; if (cap_data.size() != 6) begin errors++; $display("FAIL stall_beats got=%0d exp=6", cap_data.size()); end
        for (int i = 0; i < 6 && i < cap_data.size(); i++) begin
            checks++; if (cap_data[i] !== 32'h70 + DW'(i) || cap_last[i] !== (i == 5)) begin
                errors++; $display("FAIL stall_beat%0d got=%h/%b exp=%h/%b", i, cap_data[i], cap_last[i], 32'h70 + DW'(i), (i == 5));
            end
        end
    endtask

    task automatic test_full();
        rst = 1'b1;
        tick();
        clear_cap();
        axis_if.tready = 1'b0;
        pkt_len = PLW'(4);
        rst = 1'b0;
        // Fill during WAIT_START so nothing drains into the output register
        for (int i = 0; i < 16; i++) begin
            wren = 1'b1; din = 32'h100 + DW'(i);
            tick();
            if (i == 10) begin checks++; if (afull !== 1'b0) begin errors++; $display("FAIL afull_at11 got=%b exp=0", afull); end end
            if (i == 11) begin checks++; if (afull !== 1'b1 || level !== 5'd12) begin errors++; $display("FAIL afull_at12 got=%b/%0d exp=1/12", afull, level); end end
            if (i == 14) begin checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_at15 got=%b exp=0", full); end end
        end
        checks++; if (full !== 1'b1 || afull !== 1'b1 || level !== 5'd16) begin
            errors++; $display("FAIL full_at16 got=%b/%b/%0d exp=1/1/16", full, afull, level);
        end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_before got=%b exp=0", ovf); end
        din = 32'hDEAD;
        tick();
        wren = 1'b0;
        checks++; if (ovf !== 1'b1 || level !== 5'd16) begin errors++; $display("FAIL ovf_after got=%b/%0d exp=1/16", ovf, level); end
        axis_if.tready = 1'b1;
        wait_beats(16, 80);
        checks++; if (cap_data.size() != 16) begin errors++; $display("FAIL full_beats got=%0d exp=16", cap_data.size()); end
        for (int i = 0; i < 16 && i < cap_data.size(); i++) begin
            checks++; if (cap_data[i] !== 32'h100 + DW'(i) || cap_last[i] !== (i % 4 == 3)) begin
                errors++; $display("FAIL full_beat%0d got=%h/%b exp=%h/%b", i, cap_data[i], cap_last[i], 32'h100 + DW'(i), (i % 4 == 3));
            end
        end
        checks++; if (ovf !== 1'b1 || full !== 1'b0 || level !== 5'd0) begin
            errors++; $display("FAIL full_drained got=%b/%b/%0d exp=1/0/0", ovf, full, level);
        end
    endtask

    task automatic test_reset_mid();
        clear_cap();
        axis_if.tready = 1'b0;
        pkt_len = PLW'(4);
        write_words(2, 32'h200);
        tick();
        checks++; if (axis_if.tvalid !== 1'b1 || level !== 5'd1) begin
            errors++; $display("FAIL mid_pre got=%b/%0d exp=1/1", axis_if.tvalid, level);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (axis_if.tvalid !== 1'b0 || axis_if.tlast !== 1'b0 || level !== 5'd0 || ovf !== 1'b0) begin
            errors++; $display("FAIL mid_async got=%b/%b/%0d/%b exp=0/0/0/0", axis_if.tvalid, axis_if.tlast, level, ovf);
        end
        tick(); tick();
        rst = 1'b0;
        repeat (36) tick();
        checks++; if (cap_data.size() != 0) begin errors++; $display("FAIL mid_stale_beats got=%0d exp=0", cap_data.size()); end
        axis_if.tready = 1'b1;
        pkt_len = PLW'(2);
        write_words(2, 32'h300);
        wait_beats(2, 20);
        checks++; if (cap_data.size() != 2) begin errors++; $display("FAIL mid_next_beats got=%0d exp=2", cap_data.size()); end
        for (int i = 0; i < 2 && i < cap_data.size(); i++) begin
            checks++; if (cap_data[i] !== 32'h300 + DW'(i) || cap_last[i] !== (i == 1)) begin
                errors++; $display("FAIL mid_next%0d got=%h/%b exp=%h/%b", i, cap_data[i], cap_last[i], 32'h300 + DW'(i), (i == 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_wait_start();
        test_basic();
        test_len_clamp();
        test_flush();
        test_stall();
        test_full();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dtw_axis_pkt_master.md
DTW_AXIS_PKT_MASTER -- requirements
Module: dtw_axis_pkt_master

Interface
REQ-001 Parameter C_M_AXIS_TDATA_WIDTH, default 32, SHALL set the stream and FIFO data width (multiple of 8).
REQ-002 Parameter C_FIFO_DEPTH, default 16, SHALL set the FIFO word count (power of 2, >=4).
REQ-003 Parameter C_AFULL_THRESH, default 12, SHALL set the almost-full level (1..C_FIFO_DEPTH-1).
REQ-004 Parameter C_PKT_LEN_MAX, default 256, SHALL set the maximum beats per packet.
REQ-005 Parameter C_M_START_COUNT, default 32, SHALL set the post-reset start delay in cycles (>=1).
REQ-006 Clocking SHALL be one clock; reset SHALL be asynchronous and active-high.
REQ-007 M_AXIS_ACLK  in  1  sole clock, rising edge.
REQ-008 M_AXIS_ARESET  in  1  asynchronous, active-high reset.
REQ-009 dtw_fifo_wren  in  1  write strobe from the DTW core.
REQ-010 dtw_fifo_din  in  C_M_AXIS_TDATA_WIDTH  write data.
REQ-011 dtw_fifo_full  out  1  high when level == C_FIFO_DEPTH.
REQ-012 dtw_fifo_afull  out  1  high when level >= C_AFULL_THRESH.
REQ-013 dtw_fifo_ovf  out  1  sticky flag: a write was attempted while full.
REQ-014 fifo_level  out  clog2(C_FIFO_DEPTH+1)  current FIFO word count (excludes the output register).
REQ-015 pkt_len  in  clog2(C_PKT_LEN_MAX+1)  beats per packet; sampled at the first beat of each packet.
REQ-016 flush  in  1  single-cycle pulse that closes the current partial packet.
REQ-017 M_AXIS_TVALID / M_AXIS_TDATA / M_AXIS_TSTRB / M_AXIS_TLAST  out  1 / C_M_AXIS_TDATA_WIDTH / C_M_AXIS_TDATA_WIDTH/8 / 1  AXI4-Stream master outputs.
REQ-018 M_AXIS_TREADY  in  1  downstream ready.

Function
REQ-019 A write SHALL be accepted when dtw_fifo_wren && !dtw_fifo_full; a write while full SHALL be dropped and SHALL set dtw_fifo_ovf, even if a read occurs in the same cycle.
REQ-020 A simultaneous accepted write and read SHALL leave fifo_level unchanged; pointers SHALL wrap modulo C_FIFO_DEPTH.
REQ-021 There SHALL be no write-to-output bypass: a word written at edge k SHALL first be visible on TDATA after edge k+1 (empty FIFO, empty output register, STREAM state).
REQ-022 The state machine SHALL have states IDLE -> WAIT_START (after one cycle) -> STREAM; it SHALL leave WAIT_START after C_M_START_COUNT cycles and SHALL stay in STREAM until reset.
REQ-023 Writes SHALL be accepted in all states; reads SHALL occur only in STREAM.
REQ-024 The output register SHALL load from the FIFO when in STREAM, fifo_level > 0, and (!TVALID || TREADY).
REQ-025 TVALID, TDATA and TLAST SHALL be held stable while TVALID && !TREADY.
REQ-026 With TREADY held high and data available, throughput SHALL be one beat per cycle.
REQ-027 The beat counter SHALL increment on each loaded beat; the beat loaded at count == len-1 SHALL carry TLAST, after which the count SHALL return to 0.
REQ-028 len SHALL be pkt_len latched when loading a beat at count 0; pkt_len == 0 SHALL be treated as 1, and pkt_len > C_PKT_LEN_MAX SHALL be treated as C_PKT_LEN_MAX.
REQ-029 flush SHALL set flush_pending; a beat loaded while flush_pending && fifo_level == 1 SHALL carry TLAST, clear flush_pending and reset the count.
REQ-030 If flush_pending is set with count == 0 and fifo_level == 0, flush_pending SHALL clear with no beat emitted.
REQ-031 M_AXIS_TSTRB SHALL be constant all-ones.

Reset
REQ-032 Reset assertion SHALL immediately clear TVALID, TLAST, TDATA, dtw_fifo_full, dtw_fifo_afull, dtw_fifo_ovf, fifo_level, pointers, the beat counter, flush_pending and the start counter, and SHALL set the state to IDLE.
REQ-033 Reset mid-packet SHALL discard all buffered data; no TLAST SHALL be emitted for the aborted packet.

Structure
REQ-034 Package dtw_axis_pkg SHALL hold the state encoding and a clog2 function.
REQ-035 Storage, pointers, level and full/afull logic SHALL live in sub-module dtw_sync_fifo; the packetiser, start FSM and output register SHALL live in the top level.

Verification
REQ-036 Defaults, pkt_len=4, TREADY=1, 8 writes of 1..8 after STREAM -> beats 1..8 back-to-back, TLAST on 4 and 8.
REQ-037 16 writes with TREADY=0 -> full=1, afull=1, level=16; 17th write -> ovf=1 and word dropped; then TREADY=1 -> 16 beats in order.
REQ-038 pkt_len=8, 3 words written, flush pulsed -> third beat carries TLAST, next packet restarts at count 0.
REQ-039 TREADY toggled 1/0 per cycle during a 6-beat packet -> no TDATA/TLAST change while stalled, 6 beats total, TLAST on beat 6.
REQ-040 Writes during WAIT_START -> TVALID stays 0 until C_M_START_COUNT cycles elapse, then the data streams.
REQ-041 Reset asserted with TVALID=1 mid-packet -> TVALID=0 without a clock edge, level=0, the next packet starts with a fresh count.
